sys_bridge_n: RTL and testbench

Parametrised, registered CPU-to-peripheral bridge for the Microsystem.
- Decodes the CPU address onto NDEV device windows of 16 bytes each, starting at BASE.
- Runs each access through a small FSM with programmable wait states and a request/ack handshake.
- Latches per-device interrupt edges into a maskable pending register that drives hwint.
- Sits between the CPU data-memory port and the timer, output and input devices.

---
 rtl/sys_bridge_n.sv | 158 +++++++++++++++
 tb/tb_sys_bridge_n.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: decodes NDEV 16-byte device windows plus a control window,
// runs each access through IDLE/ACCESS/DONE with WAIT extra cycles, and latches irq edges.
module sys_bridge_n #(
  parameter int          NDEV       = 3,
  parameter logic [27:0] BASE       = 28'h0000_7f0,
  parameter int          WAIT       = 1,
  parameter logic [31:0] DEFAULT_RD = 32'h2007_4221
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prreq,
  input  logic [31:0]          praddr,
  input  logic [31:0]          prwd,
  input  logic                 weCPU,
  output logic [31:0]          prrd,
  output logic                 prack,
  output logic                 pr_busy,
  output logic                 buserr,
  output logic [1:0]           dev_addr,
  output logic [31:0]          dev_wd,
  output logic [NDEV-1:0]      dev_sel,
  output logic [NDEV-1:0]      dev_we,
  input  logic [NDEV*32-1:0]   dev_rd,
  input  logic [NDEV-1:0]      irq,
  output logic [5:0]           hwint
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {T_DEV, T_CTRL, T_NONE} tgt_t;

  localparam logic [3:0] WAIT_L = 4'(WAIT);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [2:0]      r_ch;
  logic [NDEV-1:0] r_mask;
  logic [NDEV-1:0] r_pending;
  logic [NDEV-1:0] r_irq_q;

  tgt_t            w_tgt;
  logic [2:0]      w_ch;
  logic [NDEV-1:0] w_onehot;
  logic [NDEV-1:0] w_w1c;
  logic [NDEV-1:0] w_rise;
  logic [31:0]     w_ctrl_rd;
  logic [31:0]     w_dev_rd;
  logic            w_ctrl_wr;
  logic            w_unused_addr;

  assign w_unused_addr = ^praddr[1:0];

  // Decode the incoming address; the control window sits right after the last device.
  always_comb begin
    w_tgt = T_NONE;
    w_ch  = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (praddr[31:4] == BASE + 28'(i)) begin
        w_tgt = T_DEV;
        w_ch  = 3'(i);
      end
    end
    if (praddr[31:4] == BASE + 28'(NDEV)) w_tgt = T_CTRL;
  end

  always_comb begin
    w_onehot = '0;
    w_dev_rd = '0;
    for (int i = 0; i < NDEV; i++) begin
      w_onehot[i] = (w_ch == 3'(i));
      if (r_ch == 3'(i)) w_dev_rd = dev_rd[32*i +: 32];
    end
  end

  always_comb begin
    case (praddr[3:2])
      2'd0:    w_ctrl_rd = 32'(r_mask);
      2'd1:    w_ctrl_rd = 32'(r_pending);
      default: w_ctrl_rd = '0;
    endcase
  end

  assign w_ctrl_wr = (r_state == S_IDLE) && prreq && weCPU && (w_tgt == T_CTRL);
  assign w_w1c     = (w_ctrl_wr && praddr[3:2] == 2'd1) ? prwd[NDEV-1:0] : '0;
  assign w_rise    = irq & ~r_irq_q;
  assign hwint     = 6'(r_pending & r_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_ch      <= '0;
      r_mask    <= '0;
      r_pending <= '0;
      r_irq_q   <= '0;
      prrd      <= '0;
      prack     <= 1'b0;
      pr_busy   <= 1'b0;
      buserr    <= 1'b0;
      dev_addr  <= '0;
      dev_wd    <= '0;
      dev_sel   <= '0;
      dev_we    <= '0;
    end else begin
      r_irq_q   <= irq;
      // A new edge wins over a same-cycle clear.
      r_pending <= (r_pending & ~w_w1c) | w_rise;
      case (r_state)
        S_IDLE: begin
          if (prreq) begin
            dev_addr <= praddr[3:2];
            dev_wd   <= prwd;
            r_we     <= weCPU;
            r_ch     <= w_ch;
            case (w_tgt)
              T_DEV: begin
                r_state <= S_ACCESS;
                r_cnt   <= WAIT_L;
                dev_sel <= w_onehot;
                dev_we  <= weCPU ? w_onehot : '0;
                pr_busy <= 1'b1;
              end
              T_CTRL: begin
                r_state <= S_DONE;
                prack   <= 1'b1;
                if (!weCPU) prrd <= w_ctrl_rd;
                else if (praddr[3:2] == 2'd0) r_mask <= prwd[NDEV-1:0];
              end
              default: begin
                r_state <= S_DONE;
                prack   <= 1'b1;
                buserr  <= 1'b1;
                prrd    <= DEFAULT_RD;
              end
            endcase
          end
        end
        S_ACCESS: begin
          dev_we <= '0;
          if (r_cnt == 4'd0) begin
            if (!r_we) prrd <= w_dev_rd;
            dev_sel <= '0;
            pr_busy <= 1'b0;
            prack   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          prack   <= 1'b0;
          buserr  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sys_bridge_n.sv
// Self-checking bench for sys_bridge_n: directed scenarios plus random accesses scored
// against a transaction-level model of the register map, latencies and interrupt edges.
module tb_sys_bridge_n;
  localparam int          NDEV   = 3;
  localparam int          WAIT_A = 1;
  localparam int          WAIT_B = 3;
  localparam logic [27:0] BASE   = 28'h0000_7f0;
  localparam logic [31:0] DEF    = 32'h2007_4221;

  logic clk;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        reset, prreq, weCPU, prack, pr_busy, buserr;
  logic [31:0] praddr, prwd, prrd, dev_wd;
  logic [1:0]  dev_addr;
  logic [2:0]  dev_sel, dev_we, irq;
  logic [95:0] dev_rd;
  logic [5:0]  hwint;

  logic        b_reset, b_prreq, b_weCPU, b_prack, b_pr_busy, b_buserr;
  logic [31:0] b_praddr, b_prwd, b_prrd, b_dev_wd;
  logic [1:0]  b_dev_addr;
  logic [2:0]  b_dev_sel, b_dev_we, b_irq;
  logic [95:0] b_dev_rd;
  logic [5:0]  b_hwint;

  logic [2:0]  m_mask, m_pending;
  logic [31:0] m_last_prrd;

  sys_bridge_n #(.NDEV(NDEV), .BASE(BASE), .WAIT(WAIT_A), .DEFAULT_RD(DEF)) u_dut (
    .clk(clk), .reset(reset), .prreq(prreq), .praddr(praddr), .prwd(prwd), .weCPU(weCPU),
    .prrd(prrd), .prack(prack), .pr_busy(pr_busy), .buserr(buserr), .dev_addr(dev_addr),
    .dev_wd(dev_wd), .dev_sel(dev_sel), .dev_we(dev_we), .dev_rd(dev_rd), .irq(irq),
    .hwint(hwint));

  sys_bridge_n #(.NDEV(NDEV), .BASE(BASE), .WAIT(WAIT_B), .DEFAULT_RD(DEF)) u_dut_b (
    .clk(clk), .reset(b_reset), .prreq(b_prreq), .praddr(b_praddr), .prwd(b_prwd),
    .weCPU(b_weCPU), .prrd(b_prrd), .prack(b_prack), .pr_busy(b_pr_busy), .buserr(b_buserr),
    .dev_addr(b_dev_addr), .dev_wd(b_dev_wd), .dev_sel(b_dev_sel), .dev_we(b_dev_we),
    .dev_rd(b_dev_rd), .irq(b_irq), .hwint(b_hwint));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_irq(input logic [2:0] v);
    @(negedge clk);
    m_pending = m_pending | (v & ~irq);
    irq = v;
  endtask

  // One complete CPU access on the main bridge, scored against the model.
  task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                           input logic [31:0] rdv);
    int ch, cyc, sel_cyc, we_cyc, busy_cyc, exp_lat, exp_busy;
    bit is_dev, is_ctrl, got, sel_bad, we_bad;
    logic [2:0]  exp_sel;
    logic [31:0] exp_rd;
    logic [95:0] bus;
    is_dev  = (a[31:4] >= BASE) && (a[31:4] < BASE + NDEV);
    is_ctrl = (a[31:4] == BASE + NDEV);
    ch      = is_dev ? int'(a[31:4] - BASE) : 0;
    exp_sel = is_dev ? 3'(1 << ch) : 3'b000;
    bus     = {$urandom, $urandom, $urandom};
    if (is_dev) bus[32*ch +: 32] = rdv;
    exp_rd = m_last_prrd;
    if (is_dev && !we) exp_rd = rdv;
    else if (!is_dev && !is_ctrl) exp_rd = DEF;
    else if (is_ctrl && !we)
      exp_rd = (a[3:2] == 2'd0) ? 32'(m_mask) : (a[3:2] == 2'd1) ? 32'(m_pending) : 32'd0;
    if (is_ctrl && we && a[3:2] == 2'd0) m_mask = wd[2:0];
    if (is_ctrl && we && a[3:2] == 2'd1) m_pending = m_pending & ~wd[2:0];
    m_last_prrd = exp_rd;
    exp_lat  = is_dev ? WAIT_A + 2 : 1;
    exp_busy = is_dev ? WAIT_A + 1 : 0;

    @(negedge clk);
    prreq = 1'b1; praddr = a; prwd = wd; weCPU = we; dev_rd = bus;
    cyc = 0; sel_cyc = 0; we_cyc = 0; busy_cyc = 0; got = 0; sel_bad = 0; we_bad = 0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (prack) got = 1;
      else begin
        if (pr_busy) busy_cyc++;
        if (dev_sel !== 3'b000) begin
          if (dev_sel === exp_sel) sel_cyc++; else sel_bad = 1;
        end
        if (dev_we !== 3'b000) begin
          we_cyc++;
          if (dev_we !== exp_sel || cyc != 1) we_bad = 1;
        end
        // Anything driven now must be ignored by a busy bridge.
        prreq = 1'($urandom_range(0, 1)); praddr = $urandom; prwd = $urandom;
        weCPU = 1'($urandom_range(0, 1));
      end
    end
    prreq = 1'b0;

    n_checks++;
    if (!got || cyc != exp_lat) begin
      n_errors++; $display("FAIL latency a=%h: got %0d cycles required %0d", a, cyc, exp_lat);
    end
    n_checks++;
    if (prrd !== exp_rd) begin
      n_errors++; $display("FAIL prrd a=%h we=%0d: got %h required %h", a, we, prrd, exp_rd);
    end
    n_checks++;
    if (buserr !== (!is_dev && !is_ctrl)) begin
      n_errors++; $display("FAIL buserr a=%h: got %b required %b", a, buserr, !is_dev && !is_ctrl);
    end
    n_checks++;
    if (dev_sel !== 3'b000 || dev_we !== 3'b000 || pr_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL done_idle a=%h: got sel=%b we=%b busy=%b required 000 000 0", a, dev_sel, dev_we, pr_busy);
    end
    n_checks++;
    if (busy_cyc != exp_busy) begin
      n_errors++; $display("FAIL busy_cycles a=%h: got %0d required %0d", a, busy_cyc, exp_busy);
    end
    n_checks++;
    if (sel_bad || sel_cyc != exp_busy) begin
      n_errors++; $display("FAIL dev_sel a=%h: got %0d good cycles (bad=%0d) required %0d", a, sel_cyc, sel_bad, exp_busy);
    end
    n_checks++;
    if (we_bad || we_cyc != ((is_dev && we) ? 1 : 0)) begin
      n_errors++; $display("FAIL dev_we a=%h: got %0d cycles (bad=%0d) required %0d", a, we_cyc, we_bad, (is_dev && we) ? 1 : 0);
    end
    n_checks++;
    if (dev_addr !== a[3:2] || dev_wd !== wd) begin
      n_errors++; $display("FAIL dev_latch a=%h: got %0d/%h required %0d/%h", a, dev_addr, dev_wd, a[3:2], wd);
    end
    @(negedge clk);
    n_checks++;
    if (prack !== 1'b0 || buserr !== 1'b0) begin
      n_errors++; $display("FAIL pulse a=%h: got prack=%b buserr=%b required 0 0", a, prack, buserr);
    end
    n_checks++;
    if (hwint !== {3'b000, m_pending & m_mask}) begin
      n_errors++; $display("FAIL hwint a=%h: got %b required %b", a, hwint, {3'b000, m_pending & m_mask});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; prreq = 1'b0; praddr = '0; prwd = '0; weCPU = 1'b0; dev_rd = '0; irq = '0;
    m_mask = '0; m_pending = '0; m_last_prrd = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (prack !== 1'b0 || pr_busy !== 1'b0 || buserr !== 1'b0 || prrd !== 32'd0) begin
      n_errors++; $display("FAIL reset_cpu: got prack=%b busy=%b buserr=%b prrd=%h required all 0", prack, pr_busy, buserr, prrd);
    end
    n_checks++;
    if (dev_sel !== 3'b0 || dev_we !== 3'b0 || dev_addr !== 2'b0 || dev_wd !== 32'd0 || hwint !== 6'b0) begin
      n_errors++; $display("FAIL reset_dev: got sel=%b we=%b addr=%0d wd=%h hwint=%b required all 0", dev_sel, dev_we, dev_addr, dev_wd, hwint);
    end
    reset = 1'b0;
  endtask

  task automatic test_device;
    do_access(32'h0000_7F04, 32'h0000_00AB, 1'b1, $urandom);
    do_access(32'h0000_7F28, 32'h0, 1'b0, 32'hDEAD_BEEF);
    do_access(32'h0000_7F1C, 32'h1234_5678, 1'b1, $urandom);
  endtask

  task automatic test_unmapped;
    do_access(32'h0000_8000, 32'h0, 1'b0, $urandom);
    do_access(32'h0000_7EFC, 32'h5555_AAAA, 1'b1, $urandom);
    do_access(32'h0000_7F38, 32'h0, 1'b0, $urandom);
  endtask

  task automatic test_irq;
    set_irq(3'b010);
    do_access(32'h0000_7F34, 32'h0, 1'b0, $urandom);
    n_checks++;
    if (hwint !== 6'b000000) begin
      n_errors++; $display("FAIL hwint_masked: got %b required 000000", hwint);
    end
    do_access(32'h0000_7F30, 32'h2, 1'b1, $urandom);
    n_checks++;
    if (hwint !== 6'b000010) begin
      n_errors++; $display("FAIL hwint_unmasked: got %b required 000010", hwint);
    end
    do_access(32'h0000_7F34, 32'h2, 1'b1, $urandom);
    do_access(32'h0000_7F34, 32'h0, 1'b0, $urandom);
    do_access(32'h0000_7F38, 32'hFFFF_FFFF, 1'b1, $urandom);
    do_access(32'h0000_7F3C, 32'h0, 1'b0, $urandom);
    set_irq(3'b000);
  endtask

  task automatic test_w1c_race;
    set_irq(3'b001);
    set_irq(3'b000);
    @(negedge clk);
    prreq = 1'b1; praddr = 32'h0000_7F34; prwd = 32'h1; weCPU = 1'b1; irq = 3'b001;
    m_pending = m_pending | 3'b001;
    @(negedge clk);
    prreq = 1'b0;
    n_checks++;
    if (prack !== 1'b1) begin
      n_errors++; $display("FAIL race_prack: got %b required 1", prack);
    end
    @(negedge clk);
    do_access(32'h0000_7F34, 32'h0, 1'b0, $urandom);
    set_irq(3'b000);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_rd;
    exp_rd = 32'(m_mask);
    @(negedge clk);
    prreq = 1'b1; praddr = 32'h0000_7F30; weCPU = 1'b0;
    @(negedge clk);
    n_checks++;
    if (prack !== 1'b1 || prrd !== exp_rd) begin
      n_errors++; $display("FAIL b2b_first: got prack=%b prrd=%h required 1 %h", prack, prrd, exp_rd);
    end
    praddr = 32'h0000_8000;
    @(negedge clk);
    prreq = 1'b0;
    n_checks++;
    if (prack !== 1'b0) begin
      n_errors++; $display("FAIL b2b_gap: got prack=%b required 0", prack);
    end
    @(negedge clk);
    n_checks++;
    if (prack !== 1'b0 || buserr !== 1'b0) begin
      n_errors++; $display("FAIL b2b_ignored: got prack=%b buserr=%b required 0 0", prack, buserr);
    end
    m_last_prrd = exp_rd;
    do_access(32'h0000_7F0C, 32'h0, 1'b0, $urandom);
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) set_irq(3'($urandom_range(0, 7)));
      case ($urandom_range(0, 3))
        0, 1: a = {BASE + 28'($urandom_range(0, NDEV - 1)), 4'($urandom)};
        2:    a = {BASE + 28'(NDEV), 4'($urandom)};
        default: begin
          a = $urandom;
          if (a[31:4] >= BASE && a[31:4] <= BASE + NDEV) a[31:4] = 28'h0000_800;
        end
      endcase
      do_access(a, $urandom, 1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  task automatic b_access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic [31:0] rdv, output int lat, output logic [31:0] rd);
    @(negedge clk);
    b_prreq = 1'b1; b_praddr = a; b_prwd = wd; b_weCPU = we;
    b_dev_rd = {rdv, rdv, rdv};
    lat = 0;
    do begin
      @(negedge clk);
      b_prreq = 1'b0;
      lat++;
    end while (!b_prack && lat < 50);
    rd = b_prrd;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bad;
    logic [31:0] rd, rdv;
    b_reset = 1'b1; b_prreq = 1'b0; b_praddr = '0; b_prwd = '0; b_weCPU = 1'b0;
    b_dev_rd = '0; b_irq = '0;
    repeat (2) @(negedge clk);
    b_reset = 1'b0;
    b_access(32'h0000_7F30, 32'h7, 1'b1, 32'h0, lat, rd);
    b_access(32'h0000_7F30, 32'h0, 1'b0, 32'h0, lat, rd);
    n_checks++;
    if (rd !== 32'h7) begin
      n_errors++; $display("FAIL b_mask_set: got %h required 00000007", rd);
    end
    @(negedge clk);
    b_prreq = 1'b1; b_praddr = 32'h0000_7F04; b_weCPU = 1'b0;
    @(negedge clk);
    b_prreq = 1'b0;
    n_checks++;
    if (b_dev_sel !== 3'b001 || b_pr_busy !== 1'b1) begin
      n_errors++; $display("FAIL b_in_access: got sel=%b busy=%b required 001 1", b_dev_sel, b_pr_busy);
    end
    @(negedge clk);
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    n_checks++;
    if (b_prack !== 1'b0 || b_dev_sel !== 3'b0 || b_pr_busy !== 1'b0 || b_hwint !== 6'b0) begin
      n_errors++; $display("FAIL b_abort: got prack=%b sel=%b busy=%b hwint=%b required 0 000 0 0", b_prack, b_dev_sel, b_pr_busy, b_hwint);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_prack !== 1'b0 || b_dev_we !== 3'b0 || b_dev_sel !== 3'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL b_no_late_ack: got %0d active cycles required 0", bad);
    end
    b_access(32'h0000_7F30, 32'h0, 1'b0, 32'h0, lat, rd);
    n_checks++;
    if (rd !== 32'h0 || lat != 1) begin
      n_errors++; $display("FAIL b_mask_reset: got %h lat=%0d required 00000000 lat=1", rd, lat);
    end
    rdv = $urandom;
    b_access(32'h0000_7F14, 32'h0, 1'b0, rdv, lat, rd);
    n_checks++;
    if (rd !== rdv || lat != WAIT_B + 2) begin
      n_errors++; $display("FAIL b_after_reset: got %h lat=%0d required %h lat=%0d", rd, lat, rdv, WAIT_B + 2);
    end
  endtask

  initial begin
    b_reset = 1'b1; b_prreq = 1'b0; b_praddr = '0; b_prwd = '0; b_weCPU = 1'b0;
    b_dev_rd = '0; b_irq = '0;
    test_reset();
    test_device();
    test_unmapped();
    test_irq();
    test_w1c_race();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
